// File: rtl/ha_counter.sv
// WIDTH-bit synchronous up-counter built from gate-library cells: a half_adder
// ripple chain forms the incrementer, a NAND mux picks load/increment, and DFF cells hold the count.

module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module not_gate (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

// Sum is the classic four-NAND XOR; carry is a plain AND.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c_out
);
  logic n_ab;
  logic n_a;
  logic n_b;

  nand_gate u_nand_ab (.a(a),    .b(b),    .y(n_ab));
  nand_gate u_nand_a  (.a(a),    .b(n_ab), .y(n_a));
  nand_gate u_nand_b  (.a(b),    .b(n_ab), .y(n_b));
  nand_gate u_nand_s  (.a(n_a),  .b(n_b),  .y(s));

  and_gate  u_and_c   (.a(a),    .b(b),    .y(c_out));
endmodule

// Plain D flip-flop; any reset is folded into d by the caller.
module dff_cell (
  input  logic clk,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    q <= d;
  end
endmodule

module ha_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] load_inv;
  logic [WIDTH-1:0] m_load;
  logic [WIDTH-1:0] m_inc;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] d;
  logic             rst_n;
  logic             load_n;

  // Carry-in is en itself, so with en=0 the chain passes count straight through (hold).
  assign c[0] = en;

  not_gate u_rst_inv  (.a(rst),  .y(rst_n));
  not_gate u_load_inv (.a(load), .y(load_n));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder u_ha (
      .a     (count[i]),
      .b     (c[i]),
      .s     (inc[i]),
      .c_out (c[i+1])
    );

    // nxt = load ? load_val : inc, as a 4-NAND 2:1 mux.
    nand_gate u_mux_sel (.a(load),        .b(load),        .y(load_inv[i]));
    nand_gate u_mux_a   (.a(load_val[i]), .b(load),        .y(m_load[i]));
    nand_gate u_mux_b   (.a(inc[i]),      .b(load_inv[i]), .y(m_inc[i]));
    nand_gate u_mux_o   (.a(m_load[i]),   .b(m_inc[i]),    .y(nxt[i]));

    and_gate  u_rst_gate (.a(nxt[i]), .b(rst_n), .y(d[i]));

    dff_cell  u_dff (.clk(clk), .d(d[i]), .q(count[i]));
  end

  // Ripple carry-out already includes en, so it is exactly the terminal-count flag.
  assign tc = c[WIDTH];

  logic ovf_set;
  logic ovf_n;
  logic ovf_set_n;
  logic ovf_nxt;
  logic ovf_d;

  // A load on the wrap edge suppresses the increment, so it must not set ovf either.
  and_gate  u_ovf_set   (.a(tc),      .b(load_n),    .y(ovf_set));
  not_gate  u_ovf_inv   (.a(ovf),     .y(ovf_n));
  not_gate  u_set_inv   (.a(ovf_set), .y(ovf_set_n));
  nand_gate u_ovf_or    (.a(ovf_n),   .b(ovf_set_n), .y(ovf_nxt));
  and_gate  u_ovf_rst   (.a(ovf_nxt), .b(rst_n),     .y(ovf_d));
  dff_cell  u_ovf_dff   (.clk(clk),   .d(ovf_d),     .q(ovf));

endmodule

// File: tb/tb_ha_counter.sv
// Directed table-driven bench for ha_counter plus a free-running check against a reference model.

module tb_ha_counter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  ha_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] lv;
    bit         chk_tc;
    logic       exp_tc;
    logic [3:0] exp_count;
    logic       exp_ovf;
    string      name;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic l, input logic [3:0] v,
                     input bit ct, input logic t, input logic [3:0] cnt, input logic o,
                     input string nm);
    vec_t x;
    x.rst = r; x.en = e; x.load = l; x.lv = v;
    x.chk_tc = ct; x.exp_tc = t; x.exp_count = cnt; x.exp_ovf = o; x.name = nm;
    vq.push_back(x);
  endtask

  // Drive at negedge, check tc just before the edge, check registers just after it.
  task automatic apply(input logic r, input logic e, input logic l, input logic [3:0] v);
    @(negedge clk);
    rst = r; en = e; load = l; load_val = v;
    #2;
  endtask

  logic [3:0] m_count;
  logic       m_ovf;

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'hA;

    // Reset with en/load active; tc unknown before the first reset edge.
    add(1,1,1,4'hA, 0,0, 4'h0,0, "rst1");
    add(1,1,1,4'hA, 1,0, 4'h0,0, "rst2");
    // Count up 1..5.
    add(0,1,0,4'h0, 1,0, 4'h1,0, "up1");
    add(0,1,0,4'h0, 1,0, 4'h2,0, "up2");
    add(0,1,0,4'h0, 1,0, 4'h3,0, "up3");
    add(0,1,0,4'h0, 1,0, 4'h4,0, "up4");
    add(0,1,0,4'h0, 1,0, 4'h5,0, "up5");
    // Load E, then wrap through F -> 0 -> 1.
    add(0,0,1,4'hE, 1,0, 4'hE,0, "ldE");
    add(0,1,0,4'h0, 1,0, 4'hF,0, "incE");
    add(0,1,0,4'h0, 1,1, 4'h0,1, "wrap");
    add(0,1,0,4'h0, 1,0, 4'h1,1, "post_wrap");
    // Load beats en at all-ones; ovf must stay clear.
    add(1,0,0,4'h0, 1,0, 4'h0,0, "rst3");
    add(0,0,1,4'hF, 1,0, 4'hF,0, "ldF");
    add(0,1,1,4'h3, 1,1, 4'h3,0, "ld_over_en");
    add(0,1,1,4'h9, 1,0, 4'h9,0, "ld_en_mid");
    // Set ovf, load 7, hold 4 edges, reset with everything active.
    add(0,0,1,4'hF, 1,0, 4'hF,0, "ldF2");
    add(0,1,0,4'h0, 1,1, 4'h0,1, "wrap2");
    add(0,0,1,4'h7, 1,0, 4'h7,1, "ld7");
    add(0,0,0,4'h0, 1,0, 4'h7,1, "hold1");
    add(0,0,0,4'h0, 1,0, 4'h7,1, "hold2");
    add(0,0,0,4'h0, 1,0, 4'h7,1, "hold3");
    add(0,0,0,4'h0, 1,0, 4'h7,1, "hold4");
    add(1,1,1,4'h5, 1,0, 4'h0,0, "rst_wins");

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].rst, vq[i].en, vq[i].load, vq[i].lv);
      if (vq[i].chk_tc)
        check({vq[i].name, "_tc"}, {7'd0, tc}, {7'd0, vq[i].exp_tc});
      @(posedge clk); #1;
      check({vq[i].name, "_count"}, {4'd0, count}, {4'd0, vq[i].exp_count});
      check({vq[i].name, "_ovf"},   {7'd0, ovf},   {7'd0, vq[i].exp_ovf});
    end

    // Free-run 20 edges from 0 with en toggling, against a reference model.
    m_count = 4'h0;
    m_ovf   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, (i % 2) == 0, 1'b0, 4'h0);
      check("free_tc", {7'd0, tc}, {7'd0, (en && m_count == 4'hF)});
      if (en) begin
        if (m_count == 4'hF) m_ovf = 1'b1;
        m_count = m_count + 4'h1;
      end
      @(posedge clk); #1;
      check("free_count", {4'd0, count}, {4'd0, m_count});
      check("free_ovf",   {7'd0, ovf},   {7'd0, m_ovf});
    end
    check("free_final", {4'd0, count}, 8'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
